// File: rtl/fc_seq_pkg.sv
// fc_seq_pkg: shared types and helpers for the fully-connected layer sequencer.
//   state_t : sequencer FSM states (LOAD, EVAL, EMIT)
//   acc_w() : neuron result width for a given element width and input length
package fc_seq_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Width of a neuron result: one full product plus adder-tree growth.
    function automatic int acc_w(input int width, input int n);
        return width * 2 + $clog2(n);
    endfunction

endpackage

// File: rtl/fc_in_buffer.sv
// fc_in_buffer: IN x WIDTH input-vector register file.
//   clk, rst_n : clock / asynchronous active-low reset (clears every element)
//   wr_en      : write strobe (one accepted input beat)
//   wr_idx     : element index written by this beat
//   wr_data    : element value
//   wr_last    : beat is the final one; every element above wr_idx is zeroed
//                in the same cycle so a short vector never inherits stale data
//   x_vec      : flattened vector, element i at [i*WIDTH +: WIDTH]
module fc_in_buffer #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_last,
    output logic [IN*WIDTH-1:0]   x_vec
);

    logic [IN-1:0][WIDTH-1:0] mem;

    for (genvar g = 0; g < IN; g++) begin : g_elem
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem[g] <= '0;
            end else if (wr_en) begin
                if (wr_idx == IDX_W'(g))
                    mem[g] <= wr_data;
                else if (wr_last && (IDX_W'(g) > wr_idx))
                    mem[g] <= '0;
            end
        end
    end

    assign x_vec = mem;

endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequencer for one fully-connected layer of constant-weight
// adder-tree neurons. Collects an IN-element vector, holds it on x_vec, then
// steps neuron_sel through OUT neurons, sampling z_in after a SETTLE-cycle
// window and streaming each result out on a valid/ready port.
//   in_valid/in_ready/in_data/in_last : input element stream (in_last may be early)
//   x_vec                             : registered vector to all neuron datapaths
//   neuron_sel / z_in                 : selected neuron index / its result
//   out_valid/out_ready/out_data/out_idx/out_last : result stream
//   busy                              : anything other than idle LOAD
// Optional build macro FC_SEQ_ARGMAX_EN adds class_valid/class_idx: a running
// argmax over each vector's results (strict >, ties keep the lower index).
module fc_layer_seq
    import fc_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int OUT    = 10,
    parameter int SETTLE = 2,
    localparam int ACC_W = acc_w(WIDTH, IN),
    localparam int SEL_W = $clog2(OUT),
    localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1,
    localparam int ST_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic [IN*WIDTH-1:0]  x_vec,
    output logic [SEL_W-1:0]     neuron_sel,
    input  logic [ACC_W-1:0]     z_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [SEL_W-1:0]     out_idx,
    output logic                 out_last,
`ifdef FC_SEQ_ARGMAX_EN
    output logic                 class_valid,
    output logic [SEL_W-1:0]     class_idx,
`endif
    output logic                 busy
);

    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(OUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(IN - 1);
    localparam logic [ST_W-1:0]  SETTLE_INI = ST_W'(SETTLE - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [ST_W-1:0]  settle;
    logic             beat, hs, load_done, capture;

    assign in_ready  = (state == LOAD);
    assign busy      = !((state == LOAD) && (cnt == '0));
    assign beat      = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign load_done = beat && (in_last || (cnt == LAST_IDX));
    assign capture   = (state == EVAL) && (settle == '0);

    fc_in_buffer #(.WIDTH(WIDTH), .IN(IN)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (beat),
        .wr_idx  (cnt),
        .wr_data (in_data),
        .wr_last (in_last),
        .x_vec   (x_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            settle     <= '0;
            neuron_sel <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (beat) cnt <= cnt + 1'b1;
                    if (load_done) begin
                        state      <= EVAL;
                        neuron_sel <= '0;
                        settle     <= SETTLE_INI;
                    end
                end
                EVAL: begin
                    if (capture) begin
                        out_data  <= z_in;
                        out_idx   <= neuron_sel;
                        out_last  <= (neuron_sel == LAST_SEL);
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        settle <= settle - 1'b1;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            cnt        <= '0;
                            neuron_sel <= '0;
                            state      <= LOAD;
                        end else begin
                            neuron_sel <= neuron_sel + 1'b1;
                            settle     <= SETTLE_INI;
                            state      <= EVAL;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef FC_SEQ_ARGMAX_EN
    logic [ACC_W-1:0] max_val;
    logic [SEL_W-1:0] max_idx;

    // Neuron 0's capture restarts the running max, so no result from a
    // previous vector can win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val     <= '0;
            max_idx     <= '0;
            class_valid <= 1'b0;
            class_idx   <= '0;
        end else begin
            if (capture) begin
                if (neuron_sel == '0) begin
                    max_val <= z_in;
                    max_idx <= '0;
                end else if (z_in > max_val) begin
                    max_val <= z_in;
                    max_idx <= neuron_sel;
                end
            end
            class_valid <= hs && out_last;
            if (hs && out_last) class_idx <= max_idx;
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
module tb_fc_layer_seq;
    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int OUT    = 10;
    localparam int SETTLE = 2;
    localparam int ACC_W  = 23;
    localparam int SEL_W  = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data = '0;
    logic                in_last = 1'b0;
    logic [IN*WIDTH-1:0] x_vec;
    logic [SEL_W-1:0]    neuron_sel;
    logic [ACC_W-1:0]    z_in;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [ACC_W-1:0]    out_data;
    logic [SEL_W-1:0]    out_idx;
    logic                out_last;
    logic                busy;
`ifdef FC_SEQ_ARGMAX_EN
    logic                class_valid;
    logic [SEL_W-1:0]    class_idx;
`endif

    always #5 clk = ~clk;

    fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .x_vec(x_vec), .neuron_sel(neuron_sel), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
`ifdef FC_SEQ_ARGMAX_EN
        .class_valid(class_valid), .class_idx(class_idx),
`endif
        .busy(busy)
    );

    // Neuron model: either sel*100 or a directed lookup table.
    logic zmode = 1'b0;
    int   ztab [OUT] = '{5, 9, 9, 2, 1, 0, 3, 4, 8, 7};

    always_comb begin
        z_in = '0;
        if (zmode) begin
            if (int'(neuron_sel) < OUT) z_in = ACC_W'(ztab[neuron_sel]);
        end else begin
            z_in = ACC_W'(int'(neuron_sel) * 100);
        end
    end

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [SEL_W-1:0] idx;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   cls_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int xel(input int i);
        return int'(x_vec[i*WIDTH +: WIDTH]);
    endfunction

    // Expected results for one complete vector, in order.
    task automatic push_vec();
        exp_t e;
        for (int s = 0; s < OUT; s++) begin
            e.data = zmode ? ACC_W'(ztab[s]) : ACC_W'(s * 100);
            e.idx  = SEL_W'(s);
            e.last = (s == OUT - 1);
            exp_q.push_back(e);
        end
        cls_q.push_back(zmode ? 1 : OUT - 1);
    endtask

    task automatic send_vec(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(base + i);
            in_last  = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: timeout waiting for idle, busy=%0d pending=%0d", name, busy, exp_q.size());
        end
    endtask

    task automatic wait_sel(input int v, input string name);
        int n = 0;
        while (int'(neuron_sel) != v && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: timeout waiting for neuron_sel=%0d, got %0d", name, v, neuron_sel);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: timeout waiting for out_valid", name);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        int bad = 0;
        for (int i = 0; i < IN; i++) if (xel(i) != 0) bad++;
        chk({tag, "_in_ready"},   in_ready,   1);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_neuron_sel"}, neuron_sel, 0);
        chk({tag, "_out_data"},   out_data,   0);
        chk({tag, "_out_idx"},    out_idx,    0);
        chk({tag, "_out_last"},   out_last,   0);
        chk({tag, "_x_vec_nonzero"}, bad, 0);
`ifdef FC_SEQ_ARGMAX_EN
        chk({tag, "_class_valid"}, class_valid, 0);
        chk({tag, "_class_idx"},   class_idx,   0);
`endif
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got data %0d idx %0d, no result expected", out_data, out_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_data", out_data, e.data);
                chk("result_idx",  out_idx,  e.idx);
                chk("result_last", out_last, e.last);
            end
        end
    end

`ifdef FC_SEQ_ARGMAX_EN
    always @(negedge clk) begin
        if (rst_n && class_valid) begin
            if (cls_q.size() == 0) begin
                errors++;
                $display("FAIL class_unexpected: got class_valid with idx %0d", class_idx);
            end else begin
                int c;
                c = cls_q.pop_front();
                chk("class_idx", class_idx, c);
            end
        end
    end
`endif

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 2: full vector, x[i]=i, results sel*100, SETTLE-cycle latency
        push_vec();
        send_vec(IN, 0);
        chk("full_in_ready_eval", in_ready, 0);
        chk("full_busy", busy, 1);
        chk("full_x0", xel(0), 0);
        chk("full_x77", xel(77), 77);
        chk("full_x127", xel(127), 127);
        tick();
        chk("latency_cycle1_valid", out_valid, 0);
        tick();
        chk("latency_cycle2_valid", out_valid, 1);
        chk("latency_cycle2_idx", out_idx, 0);
        wait_idle("full_vec");
        chk("full_idle_ready", in_ready, 1);

        // 3: early in_last on beat 5 zero-fills the stale tail
        push_vec();
        send_vec(6, 200);
        chk("early_in_ready_eval", in_ready, 0);
        begin
            int bad_head = 0, bad_tail = 0;
            for (int i = 0; i < 6; i++) if (xel(i) != 200 + i) bad_head++;
            for (int i = 6; i < IN; i++) if (xel(i) != 0) bad_tail++;
            chk("early_head_bad", bad_head, 0);
            chk("early_tail_nonzero", bad_tail, 0);
        end
        wait_idle("early_vec");

        // 4: backpressure on neuron 3
        push_vec();
        send_vec(IN, 0);
        wait_sel(3, "bp_sel3");
        out_ready = 1'b0;
        wait_valid("bp_valid");
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 300);
            chk("bp_out_idx", out_idx, 3);
            chk("bp_neuron_sel", neuron_sel, 3);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_idle("bp_vec");

        // 5: reset in EVAL of neuron 4, then a fresh vector restarts at idx 0
        push_vec();
        send_vec(IN, 50);
        wait_sel(4, "midrst_sel4");
        chk("midrst_in_eval", out_valid, 0);
        rst_n = 1'b0;
        exp_q.delete();
        cls_q.delete();
        tick();
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        tick();
        push_vec();
        send_vec(IN, 0);
        wait_idle("post_reset_vec");

`ifdef FC_SEQ_ARGMAX_EN
        // 6: argmax with a tie at idx 1/2 -> class 1
        zmode = 1'b1;
        push_vec();
        send_vec(IN, 0);
        wait_idle("argmax_vec");
        tick();
        tick();
        chk("argmax_class_pending", cls_q.size(), 0);
        chk("argmax_class_hold", class_idx, 1);
        chk("argmax_class_pulse_done", class_valid, 0);
        zmode = 1'b0;
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
